// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU sequencer: state encoding, op start-bit positions, error codes.
package alu_seq_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam int OP_DIV_BIT = 3;
  localparam int OP_MUL_BIT = 2;

  localparam logic [1:0] ERR_NONE       = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL_OP = 2'd1;
  localparam logic [1:0] ERR_DIV_ZERO   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT    = 2'd3;

  // Exactly one of the DIV/MUL bits selects a unit; anything else yields 0 (illegal).
  function automatic logic [4:0] op_start(input logic [4:0] op);
    logic [4:0] start;
    start = 5'd0;
    if (op[OP_DIV_BIT] && !op[OP_MUL_BIT]) start[OP_DIV_BIT] = 1'b1;
    if (op[OP_MUL_BIT] && !op[OP_DIV_BIT]) start[OP_MUL_BIT] = 1'b1;
    return start;
  endfunction

endpackage

// File: rtl/alu_seq_wdog.sv
// WAIT-state watchdog: counts enabled cycles and flags the last allowed one.
module alu_seq_wdog #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i)       count_d = '0;
    else if (enable_i) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  // Fires during the TIMEOUT_CYC-th enabled cycle so the exit edge ends that cycle.
  assign expire_o = enable_i && (count_q == LAST);

endmodule

// File: rtl/alu_seq.sv
// Non-pipelined command sequencer for MUL/DIV units. Optional watchdog: ALU_SEQ_TIMEOUT_EN.
// Handshakes: a transfer happens on any rising edge where valid and ready are both high;
// valid is never withdrawn or altered by the sender until that transfer.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_dtype,
  input  logic [4:0]  cmd_op,
  input  logic [15:0] cmd_src1,
  input  logic [15:0] cmd_src2,
  output logic [3:0]  alu_dtype,
  output logic [4:0]  alu_op,
  output logic [15:0] alu_src1,
  output logic [15:0] alu_src2,
  input  logic        alu_done,
  input  logic [31:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [1:0]  rsp_err,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  logic [1:0]  state_q, state_d;
  logic [3:0]  dtype_q, dtype_d;
  logic [4:0]  start_q, start_d;
  logic [15:0] src1_q, src1_d;
  logic [15:0] src2_q, src2_d;
  logic [31:0] result_q, result_d;
  logic [1:0]  err_q, err_d;
  logic        timeout_hit;

`ifdef ALU_SEQ_TIMEOUT_EN
  alu_seq_wdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (state_q != ST_WAIT),
    .enable_i (state_q == ST_WAIT),
    .expire_o (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    dtype_d  = dtype_q;
    start_d  = start_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          dtype_d  = cmd_dtype;
          src1_d   = cmd_src1;
          src2_d   = cmd_src2;
          start_d  = op_start(cmd_op);
          result_d = 32'd0;
          err_d    = ERR_NONE;
          if (start_d == 5'd0) begin
            state_d = ST_RESP;
            err_d   = ERR_ILLEGAL_OP;
          end else if (start_d[OP_DIV_BIT] && (cmd_src2 == 16'd0)) begin
            state_d = ST_RESP;
            err_d   = ERR_DIV_ZERO;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (alu_done) begin
          result_d = alu_result;
          err_d    = ERR_NONE;
          state_d  = ST_RESP;
        end else begin
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A done arriving in the expiry cycle still wins over the timeout.
        if (alu_done) begin
          result_d = alu_result;
          err_d    = ERR_NONE;
          state_d  = ST_RESP;
        end else if (timeout_hit) begin
          result_d = 32'd0;
          err_d    = ERR_TIMEOUT;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      dtype_q  <= 4'd0;
      start_q  <= 5'd0;
      src1_q   <= 16'd0;
      src2_q   <= 16'd0;
      result_q <= 32'd0;
      err_q    <= ERR_NONE;
    end else begin
      state_q  <= state_d;
      dtype_q  <= dtype_d;
      start_q  <= start_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign rsp_valid  = (state_q == ST_RESP);
  assign alu_op     = (state_q == ST_ISSUE) ? start_q : 5'd0;
  assign alu_dtype  = dtype_q;
  assign alu_src1   = src1_q;
  assign alu_src2   = src2_q;
  assign rsp_result = result_q;
  assign rsp_err    = err_q;
  assign dbg_state  = state_q;

endmodule
